// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128/192/256 key scheduler.
// Produces one 32-bit schedule word per clock through a single 4-byte S-box
// path and streams 128-bit round keys over a valid/ready interface.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, key_len        request + mode (00=128, 01=192, 10=256, 11=illegal)
//   key_in                cipher key, left-justified (w[0] in the top 32 bits)
//   ready                 idle, start will be accepted
//   rk_valid, rk_ready    round-key stream handshake
//   rk_data               {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_round, rk_last     round index r, high with r == Nr
//   done                  one-cycle pulse after the final round-key transfer
//   key_err               one-cycle pulse for an illegal/unsupported key_len
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start, ready=1
// ST_EXPAND | generating one schedule word per enabled cycle
// ST_DRAIN  | all words generated, waiting for the last round key to go
module key_expansion_seq #(
    parameter int MAX_NK = 8,
    parameter int KEY_W  = 32 * MAX_NK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] key_in,
    output logic             ready,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_round,
    output logic             rk_last,
    output logic             done,
    output logic             key_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DRAIN} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t      state, state_nxt;
    logic [31:0] win [MAX_NK];      // win[0] = w[i-1], win[Nk-1] = w[i-Nk]
    logic [31:0] load_win [MAX_NK];
    logic [31:0] stage [3];
    logic [3:0]  nk, nr;
    logic [5:0]  wi;                // schedule word index i
    logic [2:0]  j;                 // i mod Nk, tracked incrementally
    logic [7:0]  rcon;

    logic [3:0]  nk_sel;
    logic        legal, accept, reject;
    logic [31:0] oldest, sub_in, sub_out, cur_word;
    logic        in_key, gen_en, rk_load, gen_last, xfer, j_wrap;

    assign ready = (state == ST_IDLE);
    assign xfer  = rk_valid && rk_ready;

    always_comb begin
        case (key_len)
            2'b00:   nk_sel = 4'd4;
            2'b01:   nk_sel = 4'd6;
            2'b10:   nk_sel = 4'd8;
            default: nk_sel = 4'd0;
        endcase
    end

    assign legal  = (key_len != 2'b11) && (int'(nk_sel) <= MAX_NK);
    assign accept = (state == ST_IDLE) && start && legal;
    assign reject = (state == ST_IDLE) && start && !legal;

    // Key words are loaded oldest-first at win[Nk-1], so the first Nk
    // generation steps simply rotate them out as w[0..Nk-1] and leave the
    // window holding exactly the last Nk words.
    always_comb begin
        for (int k = 0; k < MAX_NK; k++) begin
            load_win[k] = '0;
            for (int m = 0; m < MAX_NK; m++) begin
                if (k + m + 1 == int'(nk_sel)) load_win[k] = key_in[KEY_W-1-32*m -: 32];
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int k = 0; k < MAX_NK; k++) begin
            if (k == int'(nk) - 1) oldest = win[k];
        end
    end

    assign in_key  = ({2'b00, nk} > wi);
    assign j_wrap  = ({1'b0, j} == nk - 4'd1);
    assign sub_in  = (j == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];
    assign sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                      SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};

    always_comb begin
        if (in_key)
            cur_word = oldest;
        else if (j == 3'd0)
            cur_word = oldest ^ sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && j == 3'd4)
            cur_word = oldest ^ sub_out;
        else
            cur_word = oldest ^ win[0];
    end

    // The fourth word of a round key can only be produced when the output
    // register is free this cycle; otherwise the whole schedule holds.
    assign gen_en   = (state == ST_EXPAND) && ((wi[1:0] != 2'd3) || !rk_valid || rk_ready);
    assign rk_load  = gen_en && (wi[1:0] == 2'd3);
    assign gen_last = rk_load && (wi[5:2] == nr);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_EXPAND;
            ST_EXPAND: if (gen_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (xfer && rk_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) stage[k] <= '0;
            nk       <= '0;
            nr       <= '0;
            wi       <= '0;
            j        <= '0;
            rcon     <= 8'h01;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
            done     <= 1'b0;
            key_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= (state == ST_DRAIN) && xfer && rk_last;
            key_err <= reject;
            if (accept) begin
                nk   <= nk_sel;
                nr   <= nk_sel + 4'd6;
                wi   <= '0;
                j    <= '0;
                rcon <= 8'h01;
                for (int k = 0; k < MAX_NK; k++) win[k] <= load_win[k];
            end else if (gen_en) begin
                for (int k = MAX_NK - 1; k > 0; k--) win[k] <= win[k-1];
                win[0] <= cur_word;
                wi     <= wi + 6'd1;
                j      <= j_wrap ? 3'd0 : j + 3'd1;
                if (!in_key && j == 3'd0)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                case (wi[1:0])
                    2'd0:    stage[0] <= cur_word;
                    2'd1:    stage[1] <= cur_word;
                    2'd2:    stage[2] <= cur_word;
                    default: ;
                endcase
            end
            if (rk_load) begin
                rk_valid <= 1'b1;
                rk_data  <= {stage[0], stage[1], stage[2], cur_word};
                rk_round <= wi[5:2];
                rk_last  <= (wi[5:2] == nr);
            end else if (xfer) begin
                rk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: self-checking bench for key_expansion_seq.
// Expected round keys come from an independent software key schedule (S-box
// derived from the GF(2^8) inverse + affine map) pushed into a scoreboard at
// start and popped on every rk handshake; FIPS-197 vectors spot-check rounds.
module tb_key_expansion_seq;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct packed {
        logic [3:0]   round;
        logic         last;
        logic [127:0] data;
    } exp_t;

    logic         clk, reset;
    logic         start, ready, rk_valid, rk_ready, rk_last, done, key_err;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;

    logic         start4, ready4, rk_valid4, rk_ready4, rk_last4, done4, key_err4;
    logic [1:0]   key_len4;
    logic [127:0] key_in4, rk_data4;
    logic [3:0]   rk_round4;

    key_expansion_seq #(.MAX_NK(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
        .ready(ready), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_round(rk_round), .rk_last(rk_last), .done(done), .key_err(key_err)
    );

    key_expansion_seq #(.MAX_NK(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .key_len(key_len4), .key_in(key_in4),
        .ready(ready4), .rk_valid(rk_valid4), .rk_ready(rk_ready4), .rk_data(rk_data4),
        .rk_round(rk_round4), .rk_last(rk_last4), .done(done4), .key_err(key_err4)
    );

    int           n_cmp = 0, n_err = 0;
    int           cyc = 0;
    int           xfer_cnt = 0, done_cnt = 0, done_cyc = -1, rk0_cyc = -1, last_cyc = -1;
    int           rdy_mode = 0;
    logic [7:0]   sb [256];
    logic [127:0] got [16];
    exp_t         sb_q [$];
    exp_t         mon_e;
    logic         prev_stall = 1'b0;
    logic [127:0] hold_data;
    logic [3:0]   hold_round;
    logic         hold_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (x != 0 && gmul(xb, yb) == 8'h01) inv = yb;
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic model_push(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            e.round = 4'(r);
            e.last  = (r == nr);
            e.data  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            sb_q.push_back(e);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer backpressure: either held high or random with occasional long stalls.
    initial begin
        int stall_left;
        stall_left = 0;
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                rk_ready = 1'b1;
            end else if (stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end else begin
                case ($urandom_range(0, 9))
                    0:       begin rk_ready = 1'b0; stall_left = $urandom_range(5, 20); end
                    1, 2, 3: rk_ready = 1'b0;
                    default: rk_ready = 1'b1;
                endcase
            end
        end
    end

    // Output monitor: scoreboard pops on handshakes, stall stability, timing capture.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                assert (rk_valid === 1'b1 && rk_data === hold_data && rk_round === hold_round
                        && rk_last === hold_last) else begin
                    n_err++;
                    $error("FAIL stall_hold: observed v=%0b r=%0d l=%0b d=%h expected v=1 r=%0d l=%0b d=%h",
                           rk_valid, rk_round, rk_last, rk_data, hold_round, hold_last, hold_data);
                end
            end
            if (rk_valid && rk_round == 4'd0 && rk0_cyc < 0) rk0_cyc = cyc;
            if (rk_valid && rk_last && last_cyc < 0) last_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rk_valid && rk_ready) begin
                n_cmp++;
                assert (sb_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL sb_extra: observed round %0d with empty scoreboard, expected no transfer", rk_round);
                end
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    n_cmp++;
                    assert ({rk_round, rk_last, rk_data} === {mon_e.round, mon_e.last, mon_e.data}) else begin
                        n_err++;
                        $error("FAIL rk_xfer: observed r=%0d l=%0b d=%h expected r=%0d l=%0b d=%h",
                               rk_round, rk_last, rk_data, mon_e.round, mon_e.last, mon_e.data);
                    end
                end
                got[rk_round] = rk_data;
                xfer_cnt++;
            end
            prev_stall = rk_valid && !rk_ready;
            hold_data  = rk_data;
            hold_round = rk_round;
            hold_last  = rk_last;
        end
    end

    task automatic run_op(input logic [1:0] kl, input logic [255:0] key, input int nk,
                          input bit timed, input bit poke);
        int nr, d0, acc;
        nr = nk + 6;
        model_push(key, nk);
        for (int r = 0; r < 16; r++) got[r] = '0;
        xfer_cnt = 0; rk0_cyc = -1; last_cyc = -1; done_cyc = -1;
        d0 = done_cnt;
        start = 1'b1; key_len = kl; key_in = key;
        @(posedge clk); #1;
        acc = cyc;
        start = 1'b0; key_len = 2'b10; key_in = ~key;
        chk("ready_drop", 128'(ready), 128'(0));
        if (poke) begin
            repeat (6) begin @(posedge clk); #1; end
            start = 1'b1; key_len = 2'b10; key_in = {$urandom, $urandom, $urandom, $urandom,
                                                     $urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int c = 0; c < 5000 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
        end
        chk("done_once", 128'(done_cnt - d0), 128'(1));
        chk("ready_after", 128'(ready), 128'(1));
        chk("xfer_count", 128'(xfer_cnt), 128'(nr + 1));
        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        if (timed) begin
            chk("rk0_edge", 128'(rk0_cyc - acc), 128'(4));
            chk("last_edge", 128'(last_cyc - acc), 128'(4 * nr + 4));
            chk("done_edge", 128'(done_cyc - acc), 128'(4 * nr + 5));
        end
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0;
        start4 = 1'b0; key_len4 = 2'b00; key_in4 = '0; rk_ready4 = 1'b1;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_rk_valid", 128'(rk_valid), 128'(0));
        chk("rst_rk_data", rk_data, 128'(0));
        chk("rst_rk_round", 128'(rk_round), 128'(0));
        chk("rst_rk_last", 128'(rk_last), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_key_err", 128'(key_err), 128'(0));

        // illegal key_len
        start = 1'b1; key_len = 2'b11; key_in = {8{32'h5a5a_a5a5}};
        @(posedge clk); #1;
        start = 1'b0;
        chk("kerr_pulse", 128'(key_err), 128'(1));
        chk("kerr_ready", 128'(ready), 128'(1));
        @(posedge clk); #1;
        chk("kerr_end", 128'(key_err), 128'(0));
        chk("kerr_rk_valid", 128'(rk_valid), 128'(0));
        chk("kerr_ready2", 128'(ready), 128'(1));

        // AES-256 on a MAX_NK=4 build is unsupported; AES-128 is fine
        start4 = 1'b1; key_len4 = 2'b10; key_in4 = K128;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("nk4_kerr", 128'(key_err4), 128'(1));
        chk("nk4_ready", 128'(ready4), 128'(1));
        chk("nk4_rk_valid", 128'(rk_valid4), 128'(0));
        @(posedge clk); #1;
        start4 = 1'b1; key_len4 = 2'b00; key_in4 = K128;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("nk4_accept", 128'(ready4), 128'(0));
        chk("nk4_no_kerr", 128'(key_err4), 128'(0));
        begin
            int c;
            for (c = 0; c < 100 && !done4; c++) begin @(posedge clk); #1; end
            chk("nk4_done", 128'(done4), 128'(1));
            chk("nk4_rk10", rk_data4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        // AES-128, rk_ready high, with an ignored start mid-run
        run_op(2'b00, {K128, 128'h0123456789abcdef_fedcba9876543210}, 4, 1'b1, 1'b1);
        chk("aes128_rk0", got[0], K128);
        chk("aes128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        run_op(2'b01, {K192, 64'hffff_0000_ffff_0000}, 6, 1'b1, 1'b0);
        chk("aes192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        // AES-256
        run_op(2'b10, K256, 8, 1'b1, 1'b0);
        chk("aes256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("aes256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // reset in the middle of AES-256
        model_push(K256, 8);
        xfer_cnt = 0;
        start = 1'b1; key_len = 2'b10; key_in = K256;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 500 && xfer_cnt < 5; c++) begin @(posedge clk); #1; end
        chk("mid_reach_r5", 128'(xfer_cnt), 128'(5));
        d0 = done_cnt;
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        chk("mid_rst_ready", 128'(ready), 128'(1));
        chk("mid_rst_valid", 128'(rk_valid), 128'(0));
        chk("mid_rst_round", 128'(rk_round), 128'(0));
        chk("mid_rst_data", rk_data, 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("mid_no_done", 128'(done_cnt - d0), 128'(0));
        chk("mid_idle_valid", 128'(rk_valid), 128'(0));

        // fresh AES-128 after the abandoned run
        run_op(2'b00, {K128, 128'h0}, 4, 1'b1, 1'b0);
        chk("post_rst_rk0", got[0], K128);
        chk("post_rst_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("post_rst_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-128 under random backpressure
        rdy_mode = 1;
        run_op(2'b00, {K128, 128'h1111_2222_3333_4444_5555_6666_7777_8888}, 4, 1'b0, 1'b0);
        rdy_mode = 0;
        chk("bp_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("bp_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Sequential, multi-length AES key scheduler. It covers AES-128, AES-192 and AES-256 (FIPS-197), selected per operation. It generates one 32-bit schedule word per clock using a single 4-byte S-box path and an iteratively updated Rcon. Round keys are delivered one 128-bit round key at a time over a valid/ready stream, so a cipher core consumes them round by round instead of needing a 1408-bit flat bus.

Parameters:
MAX_NK, 8, largest key length in words supported (4, 6 or 8); modes with Nk > MAX_NK are rejected; key window depth = MAX_NK
KEY_W, 256, width of key_in; fixed at 32*MAX_NK

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request new expansion; accepted only when ready=1
key_len  in  2  00=AES-128 (Nk=4,Nr=10), 01=AES-192 (Nk=6,Nr=12), 10=AES-256 (Nk=8,Nr=14), 11=illegal
key_in  in  KEY_W  cipher key, left-justified: w[0]=key_in[KEY_W-1 -: 32]; unused low bits ignored
ready  out  1  idle, can accept start
rk_valid  out  1  rk_data holds a round key
rk_ready  in  1  consumer accepts round key
rk_data  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in bits 127:96
rk_round  out  4  round index r, 0..Nr
rk_last  out  1  high with rk_valid when r=Nr
done  out  1  one-cycle pulse after the final round-key handshake
key_err  out  1  one-cycle pulse when start has illegal or unsupported key_len

Behaviour:
- Reset values: ready=1; rk_valid, rk_last, done, key_err=0; rk_data=0; rk_round=0. The internal window, word counter and Rcon are cleared (Rcon=8'h01).
- States: IDLE -> EXPAND -> DRAIN -> IDLE.
- IDLE: on start & ready with a legal key_len, latch Nk/Nr, load key words into the window, set i=0, Rcon=01, go to EXPAND; ready drops the next cycle.
- Illegal start (key_len=11 or Nk>MAX_NK): stay in IDLE, key_err pulses the next cycle, no other effect.
- EXPAND: one word w[i] is produced per enabled cycle.
  - i<Nk: w[i]=key word i.
  - i mod Nk==0: w[i]=w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}, then Rcon<=xtime(Rcon) (80->1B->36).
  - Nk==8 and i mod 8==4: w[i]=w[i-Nk] ^ SubWord(w[i-1]).
  - Otherwise: w[i]=w[i-Nk] ^ w[i-1].
  - The window is a MAX_NK-deep shift register of the last Nk words.
- Word accumulator: 3 staging words plus the current word. When i mod 4==3, the four words load rk_data and rk_valid is set, but only if the output register is empty or handshaking that cycle. Otherwise generation stalls: i, window and Rcon hold.
- Timing: with rk_ready tied high there are no bubbles. Round key r is valid after edge 4r+4, counting the accept edge as 0. The last round key appears after edge 44/52/60 for Nk=4/6/8.
- Handshake: transfer happens on rk_valid & rk_ready. rk_data, rk_round and rk_last are stable while rk_valid=1 and rk_ready=0. rk_valid drops after a transfer unless a new key loads the same cycle.
- After word 4*(Nr+1)-1 is generated, go to DRAIN. On the final transfer (rk_last), go to IDLE, pulse done the next cycle, and assert ready.
- start while ready=0 is ignored. key_in and key_len are sampled only at accept, so later changes have no effect.
- Reset asserted mid-operation: abandon the expansion, return to reset values next edge, and emit no done.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk0=key; rk1=a0fafe1788542cb123a339392a6c7605; rk10 (rk_last)=d014f9a8c9ee2589e13f0cc8b6630ca6 after edge 44; done one cycle later.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk12=e98ba06f448c773c8ecc720401002202; 13 transfers.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk2=9ba354118e6925afa51a8b5f2067fcde; rk14=fe4890d1e6188d0b046df344706c631e.
- AES-128 with random rk_ready backpressure (including long stalls) -> identical 11-key sequence, rk_* stable while stalled, no lost or duplicated rounds.
- start with key_len=11, and key_len=10 when MAX_NK=4 -> key_err pulses, ready stays 1, rk_valid stays 0.
- Reset asserted at round 5 of AES-256, then new AES-128 start -> no done; fresh correct 11-key sequence beginning with rk_round=0 and Rcon restarting at 01.
